// File: rtl/settle_pkg.sv
// Shared state encoding and constants for the settling monitor.
package settle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Sentinel for a channel that never settled; users slice it to their counter width.
    localparam int                    MAX_TO_W      = 64;
    localparam logic [MAX_TO_W-1:0]   NEVER_SETTLED = '1;

    function automatic logic [MAX_TO_W-1:0] zero_as_one(input logic [MAX_TO_W-1:0] v);
        return (v == '0) ? MAX_TO_W'(1) : v;
    endfunction

endpackage

// File: rtl/settle_chan.sv
// One monitored channel: error magnitude, hold counter, settle time, peak deviation and relapse.
module settle_chan
    import settle_pkg::*;
#(
    parameter int W    = 16,
    parameter int TO_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            active,
    input  logic [W-1:0]    sig,
    input  logic [W-1:0]    target,
    input  logic [W-1:0]    tol,
    input  logic [TO_W-1:0] hold_eff,
    input  logic [TO_W-1:0] idx,
    output logic            settled_nx,
    output logic            relapse_nx,
    output logic [TO_W-1:0] settle_time,
    output logic [W:0]      max_dev
);

    logic [W:0]      err;
    logic [W:0]      mag;
    logic            in_band;
    logic [TO_W-1:0] hcnt_inc;

    logic [TO_W-1:0] hcnt_q, hcnt_d;
    logic            settled_q, settled_d;
    logic            relapse_q, relapse_d;
    logic [TO_W-1:0] st_q, st_d;
    logic [W:0]      md_q, md_d;

    always_comb begin
        // Sign-extend both operands one bit so the difference never wraps.
        err      = {sig[W-1], sig} - {target[W-1], target};
        mag      = err[W] ? ((~err) + (W+1)'(1)) : err;
        in_band  = (mag <= {1'b0, tol});
        hcnt_inc = hcnt_q + TO_W'(1);

        hcnt_d    = hcnt_q;
        settled_d = settled_q;
        relapse_d = relapse_q;
        st_d      = st_q;
        md_d      = md_q;

        if (clear) begin
            hcnt_d    = '0;
            settled_d = 1'b0;
            relapse_d = 1'b0;
            st_d      = NEVER_SETTLED[TO_W-1:0];
            md_d      = '0;
        end else if (active) begin
            if (mag > md_q) begin
                md_d = mag;
            end
            if (!settled_q) begin
                if (in_band) begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc == hold_eff) begin
                        settled_d = 1'b1;
                        st_d      = idx - hold_eff + TO_W'(1);
                    end
                end else begin
                    hcnt_d = '0;
                end
            end else if (!in_band) begin
                relapse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q    <= '0;
            settled_q <= 1'b0;
            relapse_q <= 1'b0;
            st_q      <= NEVER_SETTLED[TO_W-1:0];
            md_q      <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            settled_q <= settled_d;
            relapse_q <= relapse_d;
            st_q      <= st_d;
            md_q      <= md_d;
        end
    end

    // Next-state views let the controller act on the deciding sample without a cycle of lag.
    assign settled_nx  = settled_d;
    assign relapse_nx  = relapse_d;
    assign settle_time = st_q;
    assign max_dev     = md_q;

endmodule

// File: rtl/settle_monitor.sv
// N-channel settling monitor: run controller, sample counter and latched run controls.
module settle_monitor
    import settle_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int W          = 16,
    parameter int TO_W       = 24,
    parameter int EARLY_EXIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NCH*W-1:0]      sig,
    input  logic [NCH*W-1:0]      target,
    input  logic [NCH*W-1:0]      tol,
    input  logic [TO_W-1:0]       hold_cycles,
    input  logic [TO_W-1:0]       timeout_cycles,
    output logic                  busy,
    output logic                  done,
    output logic [NCH-1:0]        pass,
    output logic [NCH-1:0]        relapse,
    output logic [NCH*TO_W-1:0]   settle_time,
    output logic [NCH*(W+1)-1:0]  max_dev
);

    state_t              state_q, state_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [TO_W-1:0]     hold_q, hold_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [NCH*W-1:0]    target_q, target_d;
    logic [NCH*W-1:0]    tol_q, tol_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NCH-1:0]      pass_q, pass_d;

    logic [NCH-1:0]      settled_nx;
    logic [NCH-1:0]      relapse_nx;
    logic                start_acc;
    logic                run_active;
    logic                last_sample;
    logic                early_done;

    always_comb begin
        start_acc   = (state_q == IDLE) && start;
        run_active  = (state_q == RUN);
        last_sample = (cnt_q == to_q - TO_W'(1));
        early_done  = (EARLY_EXIT != 0) && (&settled_nx);

        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        to_d     = to_q;
        target_d = target_q;
        tol_d    = tol_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    hold_d   = TO_W'(zero_as_one(MAX_TO_W'(hold_cycles)));
                    to_d     = TO_W'(zero_as_one(MAX_TO_W'(timeout_cycles)));
                    target_d = target;
                    tol_d    = tol;
                    busy_d   = 1'b1;
                    pass_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + TO_W'(1);
                // A sample that both settles and times out still counts as settled.
                if (last_sample || early_done) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    pass_d  = settled_nx & ~relapse_nx;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= TO_W'(1);
            to_q     <= TO_W'(1);
            target_q <= '0;
            tol_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            target_q <= target_d;
            tol_q    <= tol_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        settle_chan #(
            .W    (W),
            .TO_W (TO_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .clear       (start_acc),
            .active      (run_active),
            .sig         (sig[i*W +: W]),
            .target      (target_q[i*W +: W]),
            .tol         (tol_q[i*W +: W]),
            .hold_eff    (hold_q),
            .idx         (cnt_q),
            .settled_nx  (settled_nx[i]),
            .relapse_nx  (relapse_nx[i]),
            .settle_time (settle_time[i*TO_W +: TO_W]),
            .max_dev     (max_dev[i*(W+1) +: (W+1)])
        );

        assign relapse[i] = 1'b0 | u_chan.relapse_q;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_settle_monitor.sv
// Randomized bench for settle_monitor: two instances (full window and early exit) against a window-based model.
module tb_settle_monitor;

    localparam int NCH  = 2;
    localparam int W    = 16;
    localparam int TO_W = 24;
    localparam int MAXT = 1100;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NCH*W-1:0]      sig;
    logic [NCH*W-1:0]      target;
    logic [NCH*W-1:0]      tol;
    logic [TO_W-1:0]       hold_cycles;
    logic [TO_W-1:0]       timeout_cycles;

    // Index 0: EARLY_EXIT=0, index 1: EARLY_EXIT=1.
    logic                  busy_o [2];
    logic                  done_o [2];
    logic [NCH-1:0]        pass_o [2];
    logic [NCH-1:0]        rel_o  [2];
    logic [NCH*TO_W-1:0]   st_o   [2];
    logic [NCH*(W+1)-1:0]  md_o   [2];

    always #5 clk = ~clk;

    settle_monitor #(.NCH(NCH), .W(W), .TO_W(TO_W), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rst(rst), .start(start), .sig(sig), .target(target), .tol(tol),
        .hold_cycles(hold_cycles), .timeout_cycles(timeout_cycles),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .relapse(rel_o[0]),
        .settle_time(st_o[0]), .max_dev(md_o[0])
    );

    settle_monitor #(.NCH(NCH), .W(W), .TO_W(TO_W), .EARLY_EXIT(1)) dut_early (
        .clk(clk), .rst(rst), .start(start), .sig(sig), .target(target), .tol(tol),
        .hold_cycles(hold_cycles), .timeout_cycles(timeout_cycles),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .relapse(rel_o[1]),
        .settle_time(st_o[1]), .max_dev(md_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int scen    = 0;

    int samp [NCH][MAXT];
    int tgt  [NCH];
    int tl   [NCH];
    int hold_v;
    int to_v;

    int      e_done [2];
    int      e_pass [2][NCH];
    int      e_rel  [2][NCH];
    longint  e_st   [2][NCH];
    int      e_md   [2][NCH];

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mag(input int c, input int n);
        int e;
        e = samp[c][n] - tgt[c];
        return (e < 0) ? -e : e;
    endfunction

    // Settling is the first window of h consecutive in-band samples; the run covers samples 0..last.
    task automatic model();
        int h, t, last, mx, run;
        int k [NCH];
        bit all_s, settled;
        h = (hold_v == 0) ? 1 : hold_v;
        t = (to_v == 0) ? 1 : to_v;
        for (int c = 0; c < NCH; c++) begin
            k[c] = -1;
            run  = 0;
            for (int n = 0; n < t; n++) begin
                run = (mag(c, n) <= tl[c]) ? run + 1 : 0;
                if (run == h && k[c] < 0) k[c] = n;
            end
        end
        for (int d = 0; d < 2; d++) begin
            last = t - 1;
            if (d == 1) begin
                all_s = 1'b1;
                mx    = 0;
                for (int c = 0; c < NCH; c++) begin
                    if (k[c] < 0) all_s = 1'b0;
                    else if (k[c] > mx) mx = k[c];
                end
                if (all_s) last = mx;
            end
            e_done[d] = last + 1;
            for (int c = 0; c < NCH; c++) begin
                settled     = (k[c] >= 0) && (k[c] <= last);
                e_st[d][c]  = settled ? longint'(k[c] - h + 1) : 64'hFF_FFFF;
                e_rel[d][c] = 0;
                e_md[d][c]  = 0;
                for (int n = 0; n <= last; n++) begin
                    if (mag(c, n) > e_md[d][c]) e_md[d][c] = mag(c, n);
                    if (settled && n > k[c] && mag(c, n) > tl[c]) e_rel[d][c] = 1;
                end
                e_pass[d][c] = (settled && e_rel[d][c] == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic drive_sig(input int m);
        int i;
        i = (m < MAXT) ? m : MAXT - 1;
        for (int c = 0; c < NCH; c++) sig[c*W +: W] = W'(samp[c][i]);
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d busy", tag, d), busy_o[d], 0);
            chk($sformatf("%s d%0d done", tag, d), done_o[d], 0);
            chk($sformatf("%s d%0d pass", tag, d), pass_o[d], 0);
            chk($sformatf("%s d%0d relapse", tag, d), rel_o[d], 0);
            chk($sformatf("%s d%0d settle_time", tag, d), st_o[d], {NCH*TO_W{1'b1}});
            chk($sformatf("%s d%0d max_dev", tag, d), md_o[d], 0);
        end
    endtask

    task automatic run_scen(input int abort_at, input bit restart);
        int got [2];
        int rs, lim;
        logic [NCH-1:0]       cp [2];
        logic [NCH-1:0]       cr [2];
        logic [NCH*TO_W-1:0]  cs [2];
        logic [NCH*(W+1)-1:0] cm [2];
        scen++;
        model();
        rs  = restart ? (((e_done[0] < e_done[1]) ? e_done[0] : e_done[1]) / 2) : -1;
        lim = ((e_done[0] > e_done[1]) ? e_done[0] : e_done[1]) + 4;
        for (int c = 0; c < NCH; c++) begin
            target[c*W +: W] = W'(tgt[c]);
            tol[c*W +: W]    = W'(tl[c]);
        end
        hold_cycles    = TO_W'(hold_v);
        timeout_cycles = TO_W'(to_v);
        drive_sig(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            got[d] = -1; cp[d] = '0; cr[d] = '0; cs[d] = '0; cm[d] = '0;
        end
        for (int m = 0; m < lim; m++) begin
            drive_sig(m);
            start = (m == rs);
            if (m == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset($sformatf("s%0d abort", scen));
                @(posedge clk); #1;
                rst   = 1'b0;
                start = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(posedge clk); #1;
                    chk($sformatf("s%0d post_rst done0", scen), done_o[0], 0);
                    chk($sformatf("s%0d post_rst done1", scen), done_o[1], 0);
                end
                return;
            end
            for (int d = 0; d < 2; d++) begin
                if (done_o[d] && got[d] < 0) begin
                    got[d] = m; cp[d] = pass_o[d]; cr[d] = rel_o[d]; cs[d] = st_o[d]; cm[d] = md_o[d];
                end
            end
            if (got[0] >= 0 && got[1] >= 0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("s%0d d%0d done_at", scen, d), longint'(got[d]), longint'(e_done[d]));
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("s%0d d%0d c%0d pass", scen, d, c), cp[d][c], e_pass[d][c]);
                chk($sformatf("s%0d d%0d c%0d relapse", scen, d, c), cr[d][c], e_rel[d][c]);
                chk($sformatf("s%0d d%0d c%0d settle_time", scen, d, c), cs[d][c*TO_W +: TO_W], e_st[d][c]);
                chk($sformatf("s%0d d%0d c%0d max_dev", scen, d, c), cm[d][c*(W+1) +: (W+1)], e_md[d][c]);
            end
        end
        @(posedge clk); #1;
        chk($sformatf("s%0d idle busy0", scen), busy_o[0], 0);
        chk($sformatf("s%0d idle busy1", scen), busy_o[1], 0);
    endtask

    task automatic set_flat(input int tv, input int tlv, input int sv, input int h, input int t);
        hold_v = h;
        to_v   = t;
        for (int c = 0; c < NCH; c++) begin
            tgt[c] = tv;
            tl[c]  = tlv;
            for (int n = 0; n < MAXT; n++) samp[c][n] = sv;
        end
    endtask

    task automatic gen_random();
        bit wide;
        int pin, off;
        wide   = ($urandom_range(0, 7) == 0);
        hold_v = int'($urandom_range(0, 10));
        to_v   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 150));
        for (int c = 0; c < NCH; c++) begin
            if (wide) begin
                tgt[c] = int'($signed(16'($urandom)));
                tl[c]  = int'($urandom_range(0, 65535));
            end else begin
                tgt[c] = int'($urandom_range(0, 2000)) - 1000;
                tl[c]  = int'($urandom_range(0, 60));
            end
            pin = int'($urandom_range(60, 98));
            for (int n = 0; n < MAXT; n++) begin
                if (wide) begin
                    samp[c][n] = int'($signed(16'($urandom)));
                end else begin
                    if (int'($urandom_range(0, 99)) < pin) off = int'($urandom_range(0, tl[c]));
                    else off = tl[c] + 1 + int'($urandom_range(0, 80));
                    if ($urandom_range(0, 1) == 1) off = -off;
                    samp[c][n] = tgt[c] + off;
                end
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        sig            = '0;
        target         = '0;
        tol            = '0;
        hold_cycles    = '0;
        timeout_cycles = '0;
        #2;
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Immediate settle.
        set_flat(150, 200, 100, 8, 1000);
        run_scen(-1, 1'b0);

        // Never settles.
        set_flat(150, 200, 1000, 8, 1000);
        run_scen(-1, 1'b0);

        // Ringing, then holds in band from sample 40.
        set_flat(150, 200, 100, 8, 200);
        for (int c = 0; c < NCH; c++)
            for (int n = 0; n < 40; n++) samp[c][n] = (n % 2 == 1) ? 400 : 100;
        run_scen(-1, 1'b0);

        // Relapse at sample 100.
        set_flat(150, 200, 100, 8, 500);
        for (int c = 0; c < NCH; c++)
            for (int n = 100; n < MAXT; n++) samp[c][n] = 600;
        run_scen(-1, 1'b0);

        // Extremes: most-positive target, most-negative signal.
        set_flat(32767, 0, -32768, 4, 50);
        run_scen(-1, 1'b0);

        // Start pulsed mid-run is ignored.
        set_flat(150, 200, 1000, 3, 120);
        for (int n = 0; n < MAXT; n++) samp[0][n] = 100;
        run_scen(-1, 1'b1);

        // Reset at sample 20 with one channel settled and the other far off.
        set_flat(150, 200, 1000, 3, 200);
        for (int n = 0; n < MAXT; n++) samp[0][n] = 100;
        run_scen(20, 1'b0);

        // Normal run after the abort.
        set_flat(-500, 10, -495, 5, 60);
        run_scen(-1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            gen_random();
            run_scen(-1, (r % 4) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
